// File: rtl/turmite_pkg.sv
// turmite_pkg: shared types for the turmite engine.
// Headings, FSM states and turn helpers.
package turmite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    READ  = 3'd2,
    TURN  = 3'd3,
    WRITE = 3'd4
  } state_e;

  function automatic dir_e turn_right(input dir_e d);
    return dir_e'(d + 2'd1);
  endfunction

  function automatic dir_e turn_left(input dir_e d);
    return dir_e'(d - 2'd1);
  endfunction

endpackage

// File: rtl/cell_ram.sv
// cell_ram: one write port, two synchronous read ports.
// Reads return the pre-write contents on an address clash.
module cell_ram #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [DEPTH];

  // storage array, no reset: the engine clears it itself
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read ports, zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/turmite_engine.sv
// turmite_engine: multi-colour turmite on an X*Y field.
// Ant FSM, step counter and dual-read cell RAM.
module turmite_engine
  import turmite_pkg::*;
#(
  parameter int          C_NUM_OF_CELLS_X = 64,
  parameter int          C_NUM_OF_CELLS_Y = 48,
  parameter int          C_NUM_COLORS     = 2,
  parameter logic [15:0] C_RULE           = 16'h1,
  parameter int          C_WRAP           = 1,
  parameter int          C_STEP_W         = 32,
  localparam int C_COLOR_W =
    (C_NUM_COLORS > 2) ? $clog2(C_NUM_COLORS) : 1,
  localparam int XW =
    (C_NUM_OF_CELLS_X > 1) ? $clog2(C_NUM_OF_CELLS_X) : 1,
  localparam int YW =
    (C_NUM_OF_CELLS_Y > 1) ? $clog2(C_NUM_OF_CELLS_Y) : 1
) (
  input  logic                 iclk,
  input  logic                 irst_n,
  input  logic                 istart,
  input  logic                 istep,
  input  logic [YW-1:0]        line,
  input  logic [XW-1:0]        column,
  output logic [C_COLOR_W-1:0] odata,
  output logic [XW-1:0]        cur_pos_x,
  output logic [YW-1:0]        cur_pos_y,
  output logic [1:0]           odirection,
  output logic                 obusy,
  output logic                 ostep_done,
  output logic                 ohalted,
  output logic [C_STEP_W-1:0]  ostep_cnt
);

  localparam int N  = C_NUM_OF_CELLS_X * C_NUM_OF_CELLS_Y;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  localparam logic [XW-1:0] XMAX =
    XW'(C_NUM_OF_CELLS_X - 1);
  localparam logic [YW-1:0] YMAX =
    YW'(C_NUM_OF_CELLS_Y - 1);
  localparam logic [XW-1:0] HOME_X =
    XW'(C_NUM_OF_CELLS_X / 2);
  localparam logic [YW-1:0] HOME_Y =
    YW'(C_NUM_OF_CELLS_Y / 2);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [AW-1:0] XA =
    AW'(C_NUM_OF_CELLS_X);

  state_e               state;
  dir_e                 dir;
  dir_e                 dir_n_q;
  logic [AW-1:0]        clr_addr;
  logic [AW-1:0]        addr_q;
  logic [AW-1:0]        step_addr;
  logic [AW-1:0]        disp_addr;
  logic [AW-1:0]        waddr;
  logic [C_COLOR_W-1:0] rd_color;
  logic [C_COLOR_W-1:0] color_q;
  logic [C_COLOR_W-1:0] next_color;
  logic [C_COLOR_W-1:0] wdata;
  logic                 we;
  logic                 off;
  logic [XW-1:0]        nx;
  logic [YW-1:0]        ny;

  assign step_addr =
    AW'(cur_pos_y) * XA + AW'(cur_pos_x);
  assign disp_addr =
    AW'(line) * XA + AW'(column);

  assign next_color =
    (32'(color_q) == C_NUM_COLORS - 1)
      ? '0 : color_q + 1'b1;

  assign obusy      = (state != IDLE);
  assign odirection = dir;

  // write port: clear sweep or step commit; istart kills it
  always_comb begin
    we    = 1'b0;
    waddr = clr_addr;
    wdata = '0;
    if (!istart) begin
      if (state == CLEAR) begin
        we = 1'b1;
      end else if (state == WRITE) begin
        we    = 1'b1;
        waddr = addr_q;
        wdata = next_color;
      end
    end
  end

  // next position along the new heading, edge handling
  always_comb begin
    nx  = cur_pos_x;
    ny  = cur_pos_y;
    off = 1'b0;
    unique case (dir_n_q)
      DIR_UP: begin
        if (cur_pos_y != '0) ny = cur_pos_y - 1'b1;
        else if (C_WRAP != 0) ny = YMAX;
        else off = 1'b1;
      end
      DIR_RIGHT: begin
        if (cur_pos_x != XMAX) nx = cur_pos_x + 1'b1;
        else if (C_WRAP != 0) nx = '0;
        else off = 1'b1;
      end
      DIR_DOWN: begin
        if (cur_pos_y != YMAX) ny = cur_pos_y + 1'b1;
        else if (C_WRAP != 0) ny = '0;
        else off = 1'b1;
      end
      DIR_LEFT: begin
        if (cur_pos_x != '0) nx = cur_pos_x - 1'b1;
        else if (C_WRAP != 0) nx = XMAX;
        else off = 1'b1;
      end
    endcase
  end

  // ant FSM: clear sweep, then read/turn/write per step
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      cur_pos_x  <= HOME_X;
      cur_pos_y  <= HOME_Y;
      dir        <= DIR_UP;
      dir_n_q    <= DIR_UP;
      addr_q     <= '0;
      color_q    <= '0;
      ostep_done <= 1'b0;
      ohalted    <= 1'b0;
      ostep_cnt  <= '0;
    end else if (istart) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      cur_pos_x  <= HOME_X;
      cur_pos_y  <= HOME_Y;
      dir        <= DIR_UP;
      dir_n_q    <= DIR_UP;
      ostep_done <= 1'b0;
      ohalted    <= 1'b0;
      ostep_cnt  <= '0;
    end else begin
      ostep_done <= 1'b0;
      unique case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST) state <= IDLE;
        end
        IDLE: begin
          if (istep && !ohalted) state <= READ;
        end
        READ: begin
          addr_q <= step_addr;
          state  <= TURN;
        end
        TURN: begin
          color_q <= rd_color;
          dir_n_q <= C_RULE[4'(rd_color)]
                       ? turn_right(dir)
                       : turn_left(dir);
          state   <= WRITE;
        end
        WRITE: begin
          dir        <= dir_n_q;
          ostep_done <= 1'b1;
          ostep_cnt  <= ostep_cnt + 1'b1;
          if (off) begin
            ohalted <= 1'b1;
          end else begin
            cur_pos_x <= nx;
            cur_pos_y <= ny;
          end
          state <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  cell_ram #(
    .DEPTH (N),
    .AW    (AW),
    .DW    (C_COLOR_W)
  ) u_ram (
    .clk     (iclk),
    .rst_n   (irst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (step_addr),
    .rdata_a (rd_color),
    .raddr_b (disp_addr),
    .rdata_b (odata)
  );

endmodule
